// File: rtl/anc_pkg.sv
// Shared definitions for the adaptive noise canceller blocks: default sample
// width and the state encoding of the sample source controller.
package anc_pkg;

  // Default sample width shared by the sample source and adp_filter.
  localparam int ANC_DATA_W = 8;

  // Sample source controller states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    ISSUE    = 3'd2,
    GAP      = 3'd3,
    FIN      = 3'd4
  } src_state_e;

endpackage

// File: rtl/anc_pattern_rf.sv
// Noise pattern register file: DEPTH entries of DATA_W bits, cleared by the
// asynchronous reset, one synchronous write port and one combinational read
// port.
module anc_pattern_rf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: every entry returns to zero on reset, single write per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/anc_sample_source.sv
// Periodic stimulus source for the adaptive noise canceller. Replays a
// programmable noise pattern as xin and emits yin = signal level + noise
// (wrapping), one sample per handshake, for a programmed number of frames.
//
// Handshake: the source samples rdy only while waiting for a slot. rdy high
// at edge N produces a one-cycle vld pulse in cycle N+1 with xin/yin valid
// in that same cycle; the sink must accept the pair while vld is high. After
// every pulse the source idles for GAP_CYCLES cycles without looking at rdy.
// xin/yin hold their last value while vld is low.
module anc_sample_source
  import anc_pkg::*;
#(
  parameter int DATA_W     = ANC_DATA_W,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int FRAME_W    = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNT_W     = FRAME_W + AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  input  logic [DATA_W-1:0]  sig_level,
  input  logic [FRAME_W-1:0] num_frames,
  input  logic               start,
  input  logic               stop,
  input  logic               rdy,
  output logic               vld,
  output logic [DATA_W-1:0]  xin,
  output logic [DATA_W-1:0]  yin,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output src_state_e         state
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [DATA_W-1:0]  sig_q;
  logic [FRAME_W-1:0] frames_q;
  logic [FRAME_W-1:0] frame_cnt;
  logic [AW-1:0]      idx;
  logic [GW-1:0]      gap_cnt;
  logic               stop_pend;
  logic               last_q;

  logic               pat_we;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  sum;
  logic               idx_wrap;

  // The pattern is only writable while idle so a run never sees it change.
  assign pat_we   = cfg_we && (state == IDLE);
  // Noisy sample: carry out of the adder is deliberately dropped.
  assign sum      = sig_q + rd_data;
  assign idx_wrap = (idx == AW'(DEPTH - 1));

  anc_pattern_rf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_pattern (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (pat_we),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx),
    .rdata (rd_data)
  );

  // Controller: state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vld        <= 1'b0;
      xin        <= '0;
      yin        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= '0;
      sig_q      <= '0;
      frames_q   <= '0;
      frame_cnt  <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sig_q      <= sig_level;
            frames_q   <= num_frames;
            sample_cnt <= '0;
            idx        <= '0;
            frame_cnt  <= '0;
            stop_pend  <= 1'b0;
            last_q     <= 1'b0;
            busy       <= 1'b1;
            // A run requested together with stop, or with nothing to send,
            // finishes straight away but still reports completion.
            if (stop || (num_frames == '0)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= WAIT_RDY;
            end
          end
        end

        WAIT_RDY: begin
          // Stop wins over a ready sink: no further sample once stopping.
          if (stop || stop_pend) begin
            state <= FIN;
            done  <= 1'b1;
          end else if (rdy) begin
            xin   <= rd_data;
            yin   <= sum;
            vld   <= 1'b1;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          vld        <= 1'b0;
          sample_cnt <= sample_cnt + 1'b1;
          idx        <= idx + 1'b1;
          if (idx_wrap) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
          // Remember whether this was the final sample of the final frame.
          last_q  <= idx_wrap && (frame_cnt == frames_q - 1'b1);
          gap_cnt <= GW'(GAP_CYCLES);
          if (stop) begin
            stop_pend <= 1'b1;
          end
          state <= GAP;
        end

        GAP: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (gap_cnt == GW'(1)) begin
            if (last_q || stop_pend || stop) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= WAIT_RDY;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          vld   <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anc_sample_source.sv
// Bench for anc_sample_source: scoreboard of expected (xin, yin) pairs fed by
// the drivers, monitor popping on every vld pulse, plus timing checks.
module tb_anc_sample_source;
  import anc_pkg::*;

  localparam int DATA_W     = 8;
  localparam int DEPTH      = 4;
  localparam int GAP_CYCLES = 1;
  localparam int FRAME_W    = 16;
  localparam int AW         = 2;
  localparam int CNT_W      = FRAME_W + AW;
  localparam int SPACING    = GAP_CYCLES + 2;

  logic               clk;
  logic               rst_n;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [DATA_W-1:0]  cfg_wdata;
  logic [DATA_W-1:0]  sig_level;
  logic [FRAME_W-1:0] num_frames;
  logic               start;
  logic               stop;
  logic               rdy;
  logic               vld;
  logic [DATA_W-1:0]  xin;
  logic [DATA_W-1:0]  yin;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sample_cnt;
  src_state_e         state;

  anc_sample_source #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP_CYCLES),
    .FRAME_W    (FRAME_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .sig_level  (sig_level),
    .num_frames (num_frames),
    .start      (start),
    .stop       (stop),
    .rdy        (rdy),
    .vld        (vld),
    .xin        (xin),
    .yin        (yin),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [2*DATA_W-1:0] exp_q[$];
  int                  vld_log[$];
  logic [DATA_W-1:0]   model_pat [DEPTH];
  logic [DATA_W-1:0]   hold_x, hold_y;
  int                  last_vld = -100;
  bit                  rdy_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected pair per vld pulse, checks hold while idle.
  always @(negedge clk) begin
    logic [2*DATA_W-1:0] e;
    if (!rst_n) begin
      hold_x   = '0;
      hold_y   = '0;
      last_vld = -100;
    end else if (vld) begin
      vld_log.push_back(cyc);
      chk("vld_spacing", 32'(cyc - last_vld >= SPACING), 1);
      last_vld = cyc;
      chk("vld_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xin", xin, e[2*DATA_W-1:DATA_W]);
        chk("yin", yin, e[DATA_W-1:0]);
      end
      hold_x = xin;
      hold_y = yin;
    end else begin
      chk("xin_hold", xin, hold_x);
      chk("yin_hold", yin, hold_y);
    end
  end

  // Random back-pressure when enabled.
  always @(negedge clk) begin
    if (rdy_rand) rdy = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pat(input int a, input logic [DATA_W-1:0] d, input bit dut_idle);
    cfg_we    = 1'b1;
    cfg_addr  = a[AW-1:0];
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (dut_idle) model_pat[a] = d;
  endtask

  // Reference: frames x pattern entries in order, yin wraps modulo 2^DATA_W.
  task automatic push_run(input logic [DATA_W-1:0] sig, input int frames, input int limit);
    int n = 0;
    logic [DATA_W-1:0] y;
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (n < limit) begin
          y = model_pat[i] + sig;
          exp_q.push_back({model_pat[i], y});
          n++;
        end
      end
    end
  endtask

  task automatic start_run(input logic [DATA_W-1:0] sig, input int frames, output int s_edge);
    vld_log.delete();
    sig_level  = sig;
    num_frames = frames[FRAME_W-1:0];
    start      = 1'b1;
    s_edge     = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_vld(input int budget, input string name);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (vld) break;
      n++;
    end
    chk(name, vld, 1);
  endtask

  task automatic wait_done(input int budget, input int exp_cnt, output int d_cyc);
    int n = 0;
    d_cyc = -1;
    while (n < budget) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_seen", done, 1);
    if (done) begin
      d_cyc = cyc;
      chk("sample_cnt", sample_cnt, exp_cnt);
      chk("busy_in_fin", busy, 1);
      chk("exp_q_drained", exp_q.size(), 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after", busy, 0);
      chk("state_idle", state, IDLE);
    end
    exp_q.delete();
    tick();
  endtask

  task automatic load_basic();
    write_pat(0, 8'h8F, 1);
    write_pat(1, 8'h2F, 1);
    write_pat(2, 8'h8F, 1);
    write_pat(3, 8'h2F, 1);
  endtask

  // Watchdog against a hung run.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int s, d, c;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    sig_level = '0; num_frames = '0; start = 1'b0; stop = 1'b0; rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_pat[i] = '0;
    repeat (3) tick();
    chk("rst_vld", vld, 0);
    chk("rst_xin", xin, 0);
    chk("rst_yin", yin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_state", state, IDLE);
    rst_n = 1'b1;
    tick();

    // Basic frame with exact timing.
    load_basic();
    exp_q.push_back({8'h8F, 8'hA8});
    exp_q.push_back({8'h2F, 8'h48});
    exp_q.push_back({8'h8F, 8'hA8});
    exp_q.push_back({8'h2F, 8'h48});
    start_run(8'h19, 1, s);
    wait_done(100, 4, d);
    chk("basic_vld_count", vld_log.size(), 4);
    for (int k = 0; k < vld_log.size() && k < 4; k++) chk("basic_vld_cycle", vld_log[k], s + 1 + SPACING * k);
    chk("basic_done_cycle", d, s + 12);

    // Wrap arithmetic.
    write_pat(0, 8'hF0, 1);
    exp_q.push_back({8'hF0, 8'h09});
    exp_q.push_back({8'h2F, 8'h48});
    exp_q.push_back({8'h8F, 8'hA8});
    exp_q.push_back({8'h2F, 8'h48});
    start_run(8'h19, 1, s);
    wait_done(100, 4, d);

    // Back-pressure: rdy low for 7 cycles after the first sample.
    write_pat(0, 8'h8F, 1);
    push_run(8'h19, 1, 4);
    start_run(8'h19, 1, s);
    wait_vld(10, "bp_first_vld");
    rdy = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("bp_no_vld", vld, 0);
      chk("bp_xin_hold", xin, 8'h8F);
      chk("bp_yin_hold", yin, 8'hA8);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_resume", vld, 1);
    wait_done(100, 4, d);

    // Multi-frame under random back-pressure.
    for (int i = 0; i < DEPTH; i++) write_pat(i, 8'($urandom_range(0, 255)), 1);
    c = $urandom_range(0, 255);
    push_run(8'(c), 10, 40);
    rdy_rand = 1'b1;
    start_run(8'(c), 10, s);
    wait_done(2000, 40, d);
    for (int r = 0; r < 3; r++) begin
      int nf;
      for (int i = 0; i < DEPTH; i++) write_pat(i, 8'($urandom_range(0, 255)), 1);
      c  = $urandom_range(0, 255);
      nf = $urandom_range(1, 4);
      push_run(8'(c), nf, nf * DEPTH);
      start_run(8'(c), nf, s);
      wait_done(1000, nf * DEPTH, d);
    end
    rdy_rand = 1'b0;
    rdy = 1'b1;
    tick();

    // Zero frames: done one cycle after start, no samples.
    start_run(8'h33, 0, s);
    wait_done(5, 0, d);
    chk("zero_done_cycle", d, s);
    chk("zero_no_vld", vld_log.size(), 0);

    // start together with stop: no samples, done pulse.
    stop = 1'b1;
    start_run(8'h19, 2, s);
    stop = 1'b0;
    wait_done(5, 0, d);
    chk("startstop_done_cycle", d, s);
    chk("startstop_no_vld", vld_log.size(), 0);

    // Stop in WAIT_RDY after sample 2; a write while busy must be ignored.
    load_basic();
    push_run(8'h19, 3, 2);
    start_run(8'h19, 3, s);
    write_pat(0, 8'h55, 0);
    wait_vld(10, "stop_vld1");
    wait_vld(10, "stop_vld2");
    rdy = 1'b0;
    c = 0;
    while (c < 10 && state != WAIT_RDY) begin
      @(negedge clk);
      c++;
    end
    chk("stop_in_wait", state, WAIT_RDY);
    stop = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_done(3, 2, d);
    chk("stop_done_cycle", d, c + 1);
    chk("stop_vld_count", vld_log.size(), 2);
    rdy = 1'b1;
    push_run(8'h19, 1, 4);
    start_run(8'h19, 1, s);
    wait_done(100, 4, d);

    // Reset during GAP.
    push_run(8'h19, 2, 8);
    start_run(8'h19, 2, s);
    wait_vld(10, "rst_run_vld");
    @(negedge clk);
    chk("rst_in_gap", state, GAP);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", vld, 0);
    chk("midrst_xin", xin, 0);
    chk("midrst_yin", yin, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_state", state, IDLE);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model_pat[i] = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    push_run(8'h21, 1, 4);
    start_run(8'h21, 1, s);
    wait_done(100, 4, d);
    for (int i = 0; i < DEPTH; i++) write_pat(i, 8'($urandom_range(0, 255)), 1);
    c = $urandom_range(0, 255);
    push_run(8'(c), 2, 8);
    start_run(8'(c), 2, s);
    wait_done(200, 8, d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/anc_sample_source.md
Name: anc_sample_source

Overview:
Synthesizable stimulus source for the adaptive noise canceller. It stores a programmable periodic noise pattern and a constant signal level. On each handshake it emits one sample pair: reference noise xin and noisy data yin = signal + noise. It sits upstream of adp_filter and drives its xin/yin/vld inputs, honouring the filter's rdy back-pressure.

Parameters:
DATA_W, 8, sample width for xin, yin, pattern entries and signal level
DEPTH, 4, noise pattern entries per frame (power of 2, >=2)
GAP_CYCLES, 1, idle cycles forced after each vld pulse before rdy is sampled again (>=1)
FRAME_W, 16, width of the frame counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  pattern write strobe
cfg_addr  in  $clog2(DEPTH)  pattern entry index
cfg_wdata  in  DATA_W  pattern entry value
sig_level  in  DATA_W  clean signal level, latched at start
num_frames  in  FRAME_W  number of full pattern passes, latched at start
start  in  1  single-cycle run request
stop  in  1  graceful abort request
rdy  in  1  downstream ready (from adp_filter)
vld  out  1  sample valid, one-cycle pulse
xin  out  DATA_W  reference noise sample
yin  out  DATA_W  noisy data sample
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
sample_cnt  out  FRAME_W+$clog2(DEPTH)  samples issued in current/last run

Behaviour:
- Reset (async, rst_n=0): vld=0, xin=0, yin=0, busy=0, done=0, sample_cnt=0, all pattern entries=0, state=IDLE. All outputs registered.
- States: IDLE, WAIT_RDY, ISSUE, GAP, FIN.
- IDLE: busy=0. cfg_we writes pattern[cfg_addr]=cfg_wdata at the clock edge. start=1 latches sig_level and num_frames, clears sample_cnt and index. It goes to FIN if num_frames==0, else WAIT_RDY.
- Busy state: busy=1 in every state except IDLE. cfg_we is ignored and start is ignored.
- WAIT_RDY: if rdy=1 at the edge, go to ISSUE. In the same edge, register xin=pattern[idx] and yin=(sig_level+pattern[idx]) mod 2^DATA_W, with the carry discarded.
- ISSUE: vld=1 for exactly this one cycle. sample_cnt increments at exit. idx increments modulo DEPTH at exit, and frame count increments when idx wraps DEPTH-1 to 0. Next state is GAP.
- GAP: vld=0 for GAP_CYCLES cycles, using an internal down-counter, and rdy is ignored. On exit, go to FIN if the last sample of the last frame has been issued or stop is pending; else go to WAIT_RDY.
- xin/yin hold their last value whenever vld=0; they change only on entry to ISSUE.
- stop: sampled in any busy state and held as pending. A sample already in ISSUE completes. In WAIT_RDY, stop moves directly to FIN with no further sample.
- FIN: done=1 for one cycle, then IDLE. sample_cnt holds its final value until the next start.
- Handshake latency: rdy high at edge N gives vld high in cycle N+1. Minimum sample spacing is 1+GAP_CYCLES+1 cycles.
- Simultaneous events:
  - start and cfg_we in the same IDLE cycle: the write completes, and the run uses the old entry value for that address only if that index is issued before the next edge (it cannot be). The new value is therefore used.
  - start and stop together: the run is ignored, then FIN gives a done pulse.
- rst_n asserted mid-run aborts immediately to reset values. No done pulse is produced.

Decomposition:
- anc_pkg: DATA_W default constant and the src_state_e enum (IDLE, WAIT_RDY, ISSUE, GAP, FIN). adp_filter shares DATA_W.
- One sub-module: anc_pattern_rf, the DEPTH x DATA_W register file with async reset, one write port and one combinational read port.
- FSM, counters and adder stay in the top level.

Test Plan:
- Basic frame: pattern {8F,2F,8F,2F}, sig_level=0x19, num_frames=1, rdy tied 1 -> four vld pulses with (xin,yin) = (8F,A8),(2F,48),(8F,A8),(2F,48). vld spacing is 3 cycles, then done pulses, sample_cnt=4, busy drops.
- Wrap arithmetic: pattern[0]=F0, sig_level=0x19 -> yin=0x09, xin=F0.
- Back-pressure: rdy low for 7 cycles after the first sample -> vld stays 0, xin/yin hold (8F,A8), and the second sample appears the cycle after rdy returns high.
- Multi-frame and zero-frame: num_frames=10 gives 40 samples with the index repeating 0..3 and done after the 40th. num_frames=0 gives done one cycle after start with no vld.
- Stop: assert stop while in WAIT_RDY after sample 2 -> no further vld, done next cycle, sample_cnt=2. cfg_we during busy leaves the pattern unchanged, verified on the next run.
- Reset mid-run: drop rst_n during GAP -> vld/xin/yin/busy/done=0 immediately, pattern cleared, and a subsequent start with a reprogrammed pattern runs cleanly.
